// File: rtl/voice_rom_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : voice_rom_scheduler_if
// Purpose  : Bundles the voice-configuration, shared-ROM and mixed-sample
//            signals of voice_rom_scheduler into one connection.
// Ports    : sample_tick_in / voice_* config write / overrun_clr_in (to the
//            scheduler); rom_addr_out / rom_data_in (shared ROM);
//            sample_out / sample_valid_out / busy_out / active_count_out /
//            overrun_out (status and audio to the PWM stage).
//            slave  - seen from the scheduler
//            master - seen from the surrounding system (ROM, note logic, PWM)
// Revision : 1.0 - initial release
// ============================================================================
interface voice_rom_scheduler_if #(
  parameter int PHASE_WIDTH    = 24,
  parameter int ROM_ADDR_WIDTH = 8
);
  logic                      sample_tick_in;
  logic                      voice_load_in;
  logic [2:0]                voice_idx_in;
  logic                      voice_enable_in;
  logic [PHASE_WIDTH-1:0]    phase_inc_in;
  logic [7:0]                voice_gain_in;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr_out;
  logic [7:0]                rom_data_in;
  logic [15:0]               sample_out;
  logic                      sample_valid_out;
  logic                      busy_out;
  logic [2:0]                active_count_out;
  logic                      overrun_out;
  logic                      overrun_clr_in;

  modport slave (
    input  sample_tick_in, voice_load_in, voice_idx_in, voice_enable_in,
           phase_inc_in, voice_gain_in, rom_data_in, overrun_clr_in,
    output rom_addr_out, sample_out, sample_valid_out, busy_out,
           active_count_out, overrun_out
  );

  modport master (
    output sample_tick_in, voice_load_in, voice_idx_in, voice_enable_in,
           phase_inc_in, voice_gain_in, rom_data_in, overrun_clr_in,
    input  rom_addr_out, sample_out, sample_valid_out, busy_out,
           active_count_out, overrun_out
  );
endinterface
`default_nettype wire

// File: rtl/voice_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : voice_rom_scheduler
// Purpose  : Time-shares one waveform ROM among NUM_VOICES voices. Each sample
//            tick snapshots the voice configuration, walks the slots in order
//            issuing one ROM read per enabled voice, scales each returned
//            sample by the voice gain, sums, saturates and emits one 16-bit
//            sample.
// Ports    : clk_in    - system clock
//            rst_n_in  - asynchronous active-low reset
//            bus       - voice_rom_scheduler_if.slave (config writes, ROM
//                        address/data, mixed sample, busy/count/overrun)
// Revision : 1.0 - initial release
// ============================================================================
module voice_rom_scheduler #(
  parameter int NUM_VOICES     = 5,
  parameter int PHASE_WIDTH    = 24,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int ROM_LATENCY    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  voice_rom_scheduler_if.slave bus
);

  localparam int IDX_W = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_OUTPUT = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] cnt;           // slot index in ISSUE, drain cycle in DRAIN
  logic             slot_last;
  logic             drain_last;

  // FSM decoded controls
  logic start;
  logic issuing;
  logic drain_done;
  logic busy;
  logic valid;

  // Live configuration written by the note logic
  logic                   cfg_en   [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] cfg_inc  [NUM_VOICES];
  logic [7:0]             cfg_gain [NUM_VOICES];
  // Snapshot used for the period in progress
  logic                   sh_en    [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] sh_inc   [NUM_VOICES];
  logic [7:0]             sh_gain  [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] phase    [NUM_VOICES];

  logic                  write_ok;
  logic [NUM_VOICES-1:0] wr_hit;
  logic [IDX_W-1:0]      en_count;

  logic                      cur_en;
  logic [7:0]                cur_gain;
  logic [PHASE_WIDTH-1:0]    cur_phase;
  logic                      issue_en;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [ROM_ADDR_WIDTH-1:0] addr_hold;

  // Tag pipe travels alongside the ROM read so gain meets its data
  logic       tag_valid [ROM_LATENCY];
  logic [7:0] tag_gain  [ROM_LATENCY];

  logic signed [16:0] prod;
  logic signed [18:0] acc;
  logic signed [18:0] acc_sum;
  logic        [15:0] sat_sum;
  logic        [15:0] sample_reg;
  logic        [IDX_W-1:0] active_count;
  logic               overrun;

  assign slot_last  = (cnt == IDX_W'(NUM_VOICES - 1));
  assign drain_last = (cnt == IDX_W'(ROM_LATENCY - 1));

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.sample_tick_in) state_next = S_ISSUE;
      S_ISSUE:  if (slot_last)          state_next = S_DRAIN;
      S_DRAIN:  if (drain_last)         state_next = S_OUTPUT;
      S_OUTPUT:                         state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  always_comb begin
    start      = (state == S_IDLE) && bus.sample_tick_in;
    issuing    = (state == S_ISSUE);
    drain_done = (state == S_DRAIN) && drain_last;
    busy       = (state == S_ISSUE) || (state == S_DRAIN);
    valid      = (state == S_OUTPUT);
  end

  // Counter restarts on every state change, so it is the slot index in
  // ISSUE and the elapsed drain cycles in DRAIN.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Configuration registers and per-period snapshot
  // --------------------------------------------------------------------------
  assign write_ok = bus.voice_load_in && (bus.voice_idx_in < IDX_W'(NUM_VOICES));

  always_comb begin
    en_count = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      wr_hit[v] = write_ok && (bus.voice_idx_in == IDX_W'(v));
      en_count  = en_count + {{(IDX_W-1){1'b0}}, cfg_en[v]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cfg_en[v]   <= 1'b0;
        cfg_inc[v]  <= '0;
        cfg_gain[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_hit[v]) begin
          cfg_en[v]   <= bus.voice_enable_in;
          cfg_inc[v]  <= bus.phase_inc_in;
          cfg_gain[v] <= bus.voice_gain_in;
        end
      end
    end
  end

  // The snapshot reads the registers before a coincident write lands, so a
  // write in the tick cycle only affects the following period.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        sh_en[v]   <= 1'b0;
        sh_inc[v]  <= '0;
        sh_gain[v] <= '0;
      end
      active_count <= '0;
    end else if (start) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        sh_en[v]   <= cfg_en[v];
        sh_inc[v]  <= cfg_inc[v];
        sh_gain[v] <= cfg_gain[v];
      end
      active_count <= en_count;
    end
  end

  // --------------------------------------------------------------------------
  // Phase accumulators and ROM address
  // --------------------------------------------------------------------------
  assign cur_en    = sh_en[cnt];
  assign cur_gain  = sh_gain[cnt];
  assign cur_phase = phase[cnt];
  assign issue_en  = issuing && cur_en;
  assign rom_addr  = issue_en ? cur_phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH] : addr_hold;

  // A newly enabled voice restarts from phase 0; that takes priority over
  // an advance landing in the same cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_hit[v] && bus.voice_enable_in && !cfg_en[v]) begin
          phase[v] <= '0;
        end else if (issue_en && (cnt == IDX_W'(v))) begin
          phase[v] <= phase[v] + sh_inc[v];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= rom_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Tag pipe, multiply-accumulate, saturation
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_gain[i]  <= '0;
      end
    end else begin
      tag_valid[0] <= issue_en;
      tag_gain[0]  <= cur_gain;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_gain[i]  <= tag_gain[i-1];
      end
    end
  end

  // signed 8-bit sample times unsigned 8-bit gain, both widened to 17 bits
  assign prod = $signed({{9{bus.rom_data_in[7]}}, bus.rom_data_in})
              * $signed({9'b0, tag_gain[ROM_LATENCY-1]});

  assign acc_sum = tag_valid[ROM_LATENCY-1] ? (acc + {{2{prod[16]}}, prod}) : acc;

  always_comb begin
    if (acc_sum > 19'sd32767) begin
      sat_sum = 16'h7FFF;
    end else if (acc_sum < -19'sd32768) begin
      sat_sum = 16'h8000;
    end else begin
      sat_sum = acc_sum[15:0];
    end
  end

  // The last product exits the pipe in the final drain cycle, so the output
  // register is loaded from acc_sum rather than acc to meet the OUTPUT cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc        <= '0;
      sample_reg <= '0;
    end else begin
      acc <= start ? '0 : acc_sum;
      if (drain_done) begin
        sample_reg <= sat_sum;
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun <= 1'b0;
    end else if (bus.sample_tick_in && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end else if (bus.overrun_clr_in) begin
      overrun <= 1'b0;
    end
  end

  assign bus.rom_addr_out     = rom_addr;
  assign bus.sample_out       = sample_reg;
  assign bus.sample_valid_out = valid;
  assign bus.busy_out         = busy;
  assign bus.active_count_out = active_count;
  assign bus.overrun_out      = overrun;

endmodule
`default_nettype wire

// File: doc/voice_rom_scheduler.md
Name: voice_rom_scheduler

Overview:
- Time-shares one waveform ROM among NUM_VOICES synthesizer voices.
- On each sample tick, walks the voices in a fixed slot order. For each enabled voice it advances a phase accumulator, issues a ROM read, then scales the returned sample by the voice gain and accumulates it.
- Emits one saturated mixed sample per tick to the PWM stage.
- Voice configuration (enable, phase increment, gain) is written by the note-processing logic upstream.

Parameters:
- NUM_VOICES, 5, number of voice slots (voice index width 3).
- PHASE_WIDTH, 24, phase accumulator width.
- ROM_ADDR_WIDTH, 8, ROM address width; address = phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH].
- ROM_LATENCY, 2, fixed cycles from rom_addr_out to rom_data_in.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- sample_tick_in  in  1  one-cycle pulse, start of sample period
- voice_load_in  in  1  config write strobe
- voice_idx_in  in  3  voice slot being written
- voice_enable_in  in  1  enable for written voice
- phase_inc_in  in  PHASE_WIDTH  phase increment for written voice
- voice_gain_in  in  8  unsigned gain for written voice
- rom_addr_out  out  ROM_ADDR_WIDTH  shared ROM address
- rom_data_in  in  8  signed ROM sample
- sample_out  out  16  signed mixed sample
- sample_valid_out  out  1  one-cycle pulse with sample_out
- busy_out  out  1  high while a sample period is in progress
- active_count_out  out  3  enabled voices in current snapshot
- overrun_out  out  1  sticky: tick arrived while busy
- overrun_clr_in  in  1  clears overrun_out

Behaviour:
- Reset (async, rst_n_in low): all outputs 0; phases, incs, gains, enables, accumulator 0; state IDLE. Takes effect immediately, including mid-period. No sample_valid_out is emitted for an aborted period.
- Config write: accepted any cycle when voice_load_in=1 and voice_idx_in<NUM_VOICES. voice_idx_in>=NUM_VOICES is ignored.
- Enable transition: a write taking a voice from disabled to enabled clears that voice's phase to 0.
- Write timing: writes land in the config registers and take effect at the next tick snapshot. A write coincident with a tick is not in that period's snapshot.
- IDLE: on sample_tick_in, snapshot config into shadow registers, clear accumulator, set busy_out, load active_count_out, and go to ISSUE with slot=0.
- ISSUE: lasts NUM_VOICES cycles, one slot per cycle, in fixed order 0..NUM_VOICES-1.
  - Enabled slot: rom_addr_out = top bits of current phase; phase <= phase + inc, modulo 2^PHASE_WIDTH (wraps silently). Tag {valid, gain} enters a ROM_LATENCY-deep pipe.
  - Disabled slot: rom_addr_out holds its previous value, phase holds, tag is invalid.
- DRAIN: ROM_LATENCY cycles, letting the tag pipe empty.
- Accumulate: whenever a valid tag exits the pipe, acc <= acc + signed(rom_data_in) * unsigned(gain).
  - Product is 17-bit signed; range -32640..32385.
  - acc is 19-bit signed.
- OUTPUT: one cycle.
  - sample_out <= acc saturated to [-32768, 32767].
  - sample_valid_out=1; busy_out=0; return to IDLE.
  - sample_out holds until the next OUTPUT.
- Latency: tick in cycle T → ISSUE T+1..T+5 → sample_valid_out in T+8 with default parameters. In general the pulse lands at T+1+NUM_VOICES+ROM_LATENCY.
- No voices enabled: full schedule still runs; sample_out=0 at T+8.
- Tick while busy (including the OUTPUT cycle): tick is ignored, overrun_out<=1.
- overrun_out: cleared only by overrun_clr_in or reset. If a clear and an overrun occur in the same cycle, set wins.
- Ticks are never queued.

Test Plan:
- ROM model returns addr-128 (signed). Voice0 enabled, inc=0x010000, gain=1. Ticks: first sample -128 at T+8, second -127, third -126; rom_addr_out=0,1,2.
- All 5 voices gain=255, ROM constant +127 → sample_out=32767 (sum 161925 saturated). ROM constant -128 → -32768. With only voice 2 enabled, gain=2, ROM +100 → 200; active_count_out=1.
- Phase wrap: voice0 phase reaches 0xFF0000 via writes/ticks, inc=0x020000 → next address 0xFF, then phase=0x010000, next address 0x01.
- Second tick at T+4 → overrun_out=1, exactly one sample_valid_out. overrun_clr_in → 0. Clear coincident with a new overrun → stays 1.
- Write gain=4 to voice0 in the same cycle as a tick (old gain=1, ROM +10) → that sample=10, next sample=40. Write with voice_idx_in=6 → no effect.
- Assert rst_n_in low at T+3 → outputs 0 immediately, no valid pulse. After release, tick with voice0 re-enabled → phase starts at 0, address 0.
